// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: forward-select codes,
// FSM state encoding, scoreboard slot type and the slot match helper.
package hazard_ctrl_pkg;

  // Forward select coding for ctrl_rs / ctrl_rt
  localparam logic [1:0] FwdReg = 2'd0;
  localparam logic [1:0] FwdEx  = 2'd1;
  localparam logic [1:0] FwdMem = 2'd2;
  localparam logic [1:0] FwdWb  = 2'd3;

  // Redirect counter is wide enough for REDIRECT_CYCLES up to 7
  localparam int unsigned RedirCntW = 3;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLuStall  = 2'd1,
    StRedirect = 2'd2
  } state_e;

  // One in-flight destination: valid write plus register number
  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
  } sb_slot_t;

  // A slot supplies an operand only if it writes the same, non-zero register
  function automatic logic slot_hit(sb_slot_t slot, logic [4:0] src);
    return slot.vld && (slot.dst == src) && (src != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand forward select: youngest matching producer wins (EX > MEM > WB).
module hazard_ctrl_fwd_select
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  sb_slot_t   ex_i,
  input  sb_slot_t   mem_i,
  input  sb_slot_t   wb_i,
  output logic [1:0] sel_o
);

  // Priority match from the youngest stage down to the register file
  always_comb begin
    sel_o = FwdReg;
    if (slot_hit(ex_i, src_i)) begin
      sel_o = FwdEx;
    end else if (slot_hit(mem_i, src_i)) begin
      sel_o = FwdMem;
    end else if (slot_hit(wb_i, src_i)) begin
      sel_o = FwdWb;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: operand forwarding, load-use stalls, taken-jump
// redirects and external holds. Optional statistics counters are built when the macro
// HAZARD_STATS_EN is defined; otherwise stall_count/flush_count are tied to zero.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DELAY_SLOT      = 1,
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_hold,
  input  logic             id_valid,
  input  logic [15:0]      instr_top,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             ex_jump_taken,
  output logic [1:0]       ctrl_rs,
  output logic [1:0]       ctrl_rt,
  output logic             pc_we,
  output logic             if_we,
  output logic             id_we,
  output logic             if_flush,
  output logic             id_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [RedirCntW-1:0] RedirLoad = RedirCntW'(REDIRECT_CYCLES - 1);

  logic [4:0] rs, rt;
  logic       unused_opcode;

  assign rs            = instr_top[9:5];
  assign rt            = instr_top[4:0];
  assign unused_opcode = ^instr_top[15:10];

  // ---------------------------------------------------------------------------
  // Scoreboard of in-flight destinations (EX is live, MEM/WB are registered)
  // ---------------------------------------------------------------------------
  sb_slot_t ex_slot, mem_q, wb_q;

  assign ex_slot = '{vld: ex_reg_write, dst: ex_dst};

  // Shift EX -> MEM -> WB every cycle the pipeline moves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!pipe_hold) begin
      mem_q <= ex_slot;
      wb_q  <= mem_q;
    end
  end

  logic [1:0] rs_sel, rt_sel;

  hazard_ctrl_fwd_select u_fwd_rs (
    .src_i (rs),
    .ex_i  (ex_slot),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (rs_sel)
  );

  hazard_ctrl_fwd_select u_fwd_rt (
    .src_i (rt),
    .ex_i  (ex_slot),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (rt_sel)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [RedirCntW-1:0] cnt_q, cnt_d;
  logic                 load_use, jump_now, stall_now;

  assign load_use = id_valid && ex_mem_read && ex_reg_write && (ex_dst != 5'd0) &&
                    ((ex_dst == rs) || (ex_dst == rt));
  // Jumps are ignored while already redirecting; a jump outranks a load-use stall
  assign jump_now  = (state_q != StRedirect) && ex_jump_taken;
  assign stall_now = (state_q == StRun) && load_use && !jump_now;

  // State and redirect counter, frozen by pipe_hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else if (!pipe_hold) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: the jump cycle itself is the first flush cycle, so REDIRECT
  // covers the remaining REDIRECT_CYCLES-1 cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun, StLuStall: begin
        if (jump_now) begin
          cnt_d   = RedirLoad;
          state_d = (RedirLoad == '0) ? StRun : StRedirect;
        end else if (stall_now) begin
          state_d = StLuStall;
        end else begin
          state_d = StRun;
        end
      end
      StRedirect: begin
        if (cnt_q <= RedirCntW'(1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - RedirCntW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StRun;
      end
    endcase
  end

  // Outputs: reset forces the idle pattern, hold overrides everything else
  always_comb begin
    ctrl_rs  = FwdReg;
    ctrl_rt  = FwdReg;
    pc_we    = 1'b1;
    if_we    = 1'b1;
    id_we    = 1'b1;
    if_flush = 1'b0;
    id_flush = 1'b0;
    if (reset) begin
      ctrl_rs = rs_sel;
      ctrl_rt = rt_sel;
      if (pipe_hold) begin
        pc_we = 1'b0;
        if_we = 1'b0;
        id_we = 1'b0;
      end else if (jump_now) begin
        if_flush = 1'b1;
        id_flush = (DELAY_SLOT == 0);
      end else if (state_q == StRedirect) begin
        if_flush = 1'b1;
      end else if (stall_now) begin
        pc_we    = 1'b0;
        if_we    = 1'b0;
        id_flush = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating increments on stall assertion and redirect entry
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_now && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (jump_now && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, frozen by pipe_hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!pipe_hold) begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (delay slot + 3 redirect cycles, and no delay
// slot + 1 redirect cycle) share one vector table; expectations go through a queue
// and are compared on the falling edge.
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  // {pc_we, if_we, id_we, if_flush, id_flush}
  localparam logic [4:0] N  = 5'b11100;
  localparam logic [4:0] S  = 5'b00101;
  localparam logic [4:0] H  = 5'b00000;
  localparam logic [4:0] F  = 5'b11110;
  localparam logic [4:0] FF = 5'b11111;
  localparam int NumVec = 36;

  typedef struct {
    logic       rst_n, hold, idv, rw, mr, jmp;
    logic [4:0] rs, rt, dst;
    logic [8:0] ea, eb;
  } vec_t;

  typedef struct {
    int          idx;
    logic [8:0]  ea, eb;
    bit          cnt;
    logic [31:0] as, af, bs, bf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, hold, idv, rw, mr, jmp;
  logic [4:0]  rs, rt, dst;
  logic [15:0] instr;
  logic [1:0]  a_rs, a_rt, b_rs, b_rt;
  logic        a_pc, a_if, a_id, a_iff, a_idf, b_pc, b_if, b_id, b_iff, b_idf;
  logic [31:0] a_sc, a_fc, b_sc, b_fc;

  vec_t tv[NumVec];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  assign instr = {6'h23, rs, rt};

  always #5 clk = ~clk;

  hazard_ctrl #(.DELAY_SLOT(1), .REDIRECT_CYCLES(3), .CNT_W(32)) u_dut_a (
    .clk(clk), .reset(rst_n), .pipe_hold(hold), .id_valid(idv), .instr_top(instr),
    .ex_reg_write(rw), .ex_mem_read(mr), .ex_dst(dst), .ex_jump_taken(jmp),
    .ctrl_rs(a_rs), .ctrl_rt(a_rt), .pc_we(a_pc), .if_we(a_if), .id_we(a_id),
    .if_flush(a_iff), .id_flush(a_idf), .stall_count(a_sc), .flush_count(a_fc)
  );

  hazard_ctrl #(.DELAY_SLOT(0), .REDIRECT_CYCLES(1), .CNT_W(32)) u_dut_b (
    .clk(clk), .reset(rst_n), .pipe_hold(hold), .id_valid(idv), .instr_top(instr),
    .ex_reg_write(rw), .ex_mem_read(mr), .ex_dst(dst), .ex_jump_taken(jmp),
    .ctrl_rs(b_rs), .ctrl_rt(b_rt), .pc_we(b_pc), .if_we(b_if), .id_we(b_id),
    .if_flush(b_iff), .id_flush(b_idf), .stall_count(b_sc), .flush_count(b_fc)
  );

  function automatic logic [8:0] e(input logic [1:0] s_rs, input logic [1:0] s_rt,
                                   input logic [4:0] ctl);
    return {s_rs, s_rt, ctl};
  endfunction

  function automatic vec_t mk(input logic r, input logic h, input logic v, input logic [4:0] s1,
                              input logic [4:0] s2, input logic w, input logic m,
                              input logic [4:0] d, input logic j, input logic [8:0] xa,
                              input logic [8:0] xb);
    vec_t t;
    t.rst_n = r; t.hold = h; t.idv = v; t.rs = s1; t.rt = s2;
    t.rw = w; t.mr = m; t.dst = d; t.jmp = j; t.ea = xa; t.eb = xb;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Scoreboard consumer: one expectation per driven cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t it;
      it = sbq.pop_front();
      check("dut_a_outputs", it.idx, 32'({a_rs, a_rt, a_pc, a_if, a_id, a_iff, a_idf}),
            32'(it.ea));
      check("dut_b_outputs", it.idx, 32'({b_rs, b_rt, b_pc, b_if, b_id, b_iff, b_idf}),
            32'(it.eb));
      if (it.cnt) begin
        check("dut_a_stall_count", it.idx, a_sc, it.as);
        check("dut_a_flush_count", it.idx, a_fc, it.af);
        check("dut_b_stall_count", it.idx, b_sc, it.bs);
        check("dut_b_flush_count", it.idx, b_fc, it.bf);
      end
    end
  end

  initial begin
    exp_t it;
    rst_n = 1'b0; hold = 1'b0; idv = 1'b0; rw = 1'b0; mr = 1'b0; jmp = 1'b0;
    rs = '0; rt = '0; dst = '0;

    // reset with hazardous inputs: outputs must stay idle
    tv[0]  = mk(0, 0, 1, 5, 0, 1, 1, 5, 1, e(0, 0, N), e(0, 0, N));
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    // EX / MEM / WB forwarding of r5, then aged out
    tv[2]  = mk(1, 0, 1, 5, 0, 1, 0, 5, 0, e(1, 0, N), e(1, 0, N));
    tv[3]  = mk(1, 0, 1, 5, 0, 0, 0, 0, 0, e(2, 0, N), e(2, 0, N));
    tv[4]  = mk(1, 0, 1, 5, 0, 0, 0, 0, 0, e(3, 0, N), e(3, 0, N));
    tv[5]  = mk(1, 0, 1, 5, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    // writes to r0 never forward
    tv[6]  = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    tv[7]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    tv[8]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    // priority and mixed operands
    tv[9]  = mk(1, 0, 1, 0, 7, 1, 0, 7, 0, e(0, 1, N), e(0, 1, N));
    tv[10] = mk(1, 0, 1, 0, 7, 1, 0, 7, 0, e(0, 1, N), e(0, 1, N));
    tv[11] = mk(1, 0, 1, 7, 7, 1, 0, 9, 0, e(2, 2, N), e(2, 2, N));
    tv[12] = mk(1, 0, 1, 9, 7, 0, 0, 0, 0, e(2, 3, N), e(2, 3, N));
    tv[13] = mk(1, 0, 1, 9, 9, 0, 0, 0, 0, e(3, 3, N), e(3, 3, N));
    // load-use on rt=r8, then load in MEM
    tv[14] = mk(1, 0, 1, 0, 8, 1, 1, 8, 0, e(0, 1, S), e(0, 1, S));
    tv[15] = mk(1, 0, 1, 0, 8, 0, 0, 0, 0, e(0, 2, N), e(0, 2, N));
    // no stall without a valid ID instruction, or for a load to r0
    tv[16] = mk(1, 0, 0, 0, 8, 1, 1, 8, 0, e(0, 1, N), e(0, 1, N));
    tv[17] = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, e(0, 0, N), e(0, 0, N));
    // load-use on rs=r3, then 4 held cycles in LU_STALL
    tv[18] = mk(1, 0, 1, 3, 0, 1, 1, 3, 0, e(1, 0, S), e(1, 0, S));
    for (int i = 19; i <= 22; i++) tv[i] = mk(1, 1, 1, 3, 0, 0, 0, 0, 0, e(2, 0, H), e(2, 0, H));
    tv[23] = mk(1, 0, 1, 3, 0, 0, 0, 0, 0, e(2, 0, N), e(2, 0, N));
    // taken jump; load-use during REDIRECT is suppressed on A only
    tv[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 0, F), e(0, 0, FF));
    tv[25] = mk(1, 0, 1, 0, 4, 1, 1, 4, 0, e(0, 1, F), e(0, 1, S));
    tv[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, F), e(0, 0, N));
    tv[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    // reset in the middle of a redirect
    tv[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 0, F), e(0, 0, FF));
    tv[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    tv[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    tv[31] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));
    // jump together with a load-use: jump wins
    tv[32] = mk(1, 0, 1, 0, 6, 1, 1, 6, 1, e(0, 1, F), e(0, 1, FF));
    tv[33] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, F), e(0, 0, N));
    tv[34] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, F), e(0, 0, N));
    tv[35] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, N), e(0, 0, N));

    for (int i = 0; i < NumVec; i++) begin
      @(posedge clk);
      #1;
      rst_n = tv[i].rst_n; hold = tv[i].hold; idv = tv[i].idv; rs = tv[i].rs;
      rt = tv[i].rt; rw = tv[i].rw; mr = tv[i].mr; dst = tv[i].dst; jmp = tv[i].jmp;
      it = '{idx: i, ea: tv[i].ea, eb: tv[i].eb, cnt: 1'b0, as: 0, af: 0, bs: 0, bf: 0};
      if (i == 27) begin
        it.cnt = 1'b1;
        it.as = Stats ? 32'd2 : 32'd0;
        it.af = Stats ? 32'd1 : 32'd0;
        it.bs = Stats ? 32'd3 : 32'd0;
        it.bf = Stats ? 32'd1 : 32'd0;
      end else if (i == 35) begin
        it.cnt = 1'b1;
        it.as = 32'd0;
        it.af = Stats ? 32'd1 : 32'd0;
        it.bs = 32'd0;
        it.bf = Stats ? 32'd1 : 32'd0;
      end
      sbq.push_back(it);
    end

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 4 && sbq.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
